// File: rtl/debug_volcado_datos.sv
// Data-memory dump engine: reads every cell through the debug port and streams
// each word MSB-first as bytes over a valid/ready handshake to the UART TX.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for i_Start, address forced to 0
//   ST_WAIT | address driven, memory read settles, word captured at edge
//   ST_SEND | shadow top byte offered, shifts out on each accepted byte
//   ST_DONE | one-cycle completion pulse
module debug_volcado_datos #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 16,
  parameter int NBYTE  = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Start,
  output logic [NBITS-1:0] o_DebugDireccion,
  input  logic [NBITS-1:0] i_DebugDato,
  output logic [NBYTE-1:0] o_TxDato,
  output logic             o_TxValid,
  input  logic             i_TxReady,
  output logic             o_Busy,
  output logic             o_Done
);

  localparam int NB  = NBITS / NBYTE;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int WCW = (CELDAS > 1) ? $clog2(CELDAS) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(CELDAS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND, ST_DONE} state_t;

  state_t           state_q,  state_d;
  logic [WCW-1:0]   word_q,   word_d;
  logic [BCW-1:0]   byte_q,   byte_d;
  logic [NBITS-1:0] shadow_q, shadow_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      byte_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      byte_q   <= byte_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    byte_d   = byte_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          word_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        shadow_d = i_DebugDato;
        byte_d   = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        // Nothing moves until the byte is accepted, so backpressure holds everything.
        if (i_TxReady) begin
          if (byte_q != LAST_BYTE) begin
            shadow_d = shadow_q << NBYTE;
            byte_d   = byte_q + 1'b1;
          end else if (word_q == LAST_WORD) begin
            state_d = ST_DONE;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_TxValid        = (state_q == ST_SEND);
  assign o_TxDato         = o_TxValid ? shadow_q[NBITS-1 -: NBYTE] : '0;
  assign o_Busy           = (state_q != ST_IDLE);
  assign o_Done           = (state_q == ST_DONE);
  assign o_DebugDireccion = (state_q == ST_IDLE) ? '0 : NBITS'(word_q);

endmodule
